// File: rtl/dll_pkg.sv
// ---------------------------------------------------------------------------
// dll_pkg
// Shared definitions for the VC0 flow-control initialisation engine:
//   - DLCM state encoding as driven by the DLCM state machine
//   - DLLP type byte constants (VC ID field in bits [2:0] is always 0 here)
//   - FC credit type enumeration
//   - helpers to build an FC DLLP body and to pull fields back out of one
// DLLP body layout (no CRC): byte0 in [31:24]
//   byte0 = type, byte1 = {2'b00, Hdr[7:2]},
//   byte2 = {Hdr[1:0], 2'b00, Data[11:8]}, byte3 = Data[7:0]
// ---------------------------------------------------------------------------
package dll_pkg;

    typedef enum logic [1:0] {
        DLCM_INACTIVE = 2'd0,
        DLCM_INIT1    = 2'd1,
        DLCM_INIT2    = 2'd2,
        DLCM_ACTIVE   = 2'd3
    } dlcm_state_e;

    typedef enum logic [1:0] {
        FC_P   = 2'd0,
        FC_NP  = 2'd1,
        FC_CPL = 2'd2
    } fc_type_e;

    localparam logic [7:0] DLLP_INITFC1_P   = 8'h40;
    localparam logic [7:0] DLLP_INITFC1_NP  = 8'h50;
    localparam logic [7:0] DLLP_INITFC1_CPL = 8'h60;
    localparam logic [7:0] DLLP_INITFC2_P   = 8'hC0;
    localparam logic [7:0] DLLP_INITFC2_NP  = 8'hD0;
    localparam logic [7:0] DLLP_INITFC2_CPL = 8'hE0;
    localparam logic [7:0] DLLP_UPDFC_P     = 8'h80;
    localparam logic [7:0] DLLP_UPDFC_NP    = 8'h90;
    localparam logic [7:0] DLLP_UPDFC_CPL   = 8'hA0;

    // Type byte for an InitFC DLLP of the given credit type and phase.
    function automatic logic [7:0] init_fc_code(input logic init2, input fc_type_e t);
        logic [7:0] code;
        case (t)
            FC_P:    code = init2 ? DLLP_INITFC2_P   : DLLP_INITFC1_P;
            FC_NP:   code = init2 ? DLLP_INITFC2_NP  : DLLP_INITFC1_NP;
            default: code = init2 ? DLLP_INITFC2_CPL : DLLP_INITFC1_CPL;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] build_fc_dllp(input logic [7:0]  typ,
                                                  input logic [7:0]  hdr,
                                                  input logic [11:0] data);
        return {typ, 2'b00, hdr[7:2], hdr[1:0], 2'b00, data[11:8], data[7:0]};
    endfunction

    function automatic logic [7:0] dllp_type(input logic [31:0] d);
        return d[31:24];
    endfunction

    function automatic logic [7:0] dllp_hdr_fc(input logic [31:0] d);
        return {d[21:16], d[15:14]};
    endfunction

    function automatic logic [11:0] dllp_data_fc(input logic [31:0] d);
        return d[11:0];
    endfunction

endpackage

// File: rtl/dll_fc_rx_tracker.sv
// ---------------------------------------------------------------------------
// dll_fc_rx_tracker
// Decodes DLLPs received from the link partner during flow-control init.
// Tracks which InitFC credit types have been seen, the FI2 condition, and
// latches the partner's first advertised credits per type.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   dlcm_state      current DLCM state (dll_pkg::dlcm_state_e encoding)
//   rx_valid/data   CRC-checked received DLLP body
//   rx_tlp_valid    good TLP received (counts towards FI2)
//   fi1_cond        FI1 including any flag being set this cycle
//   fi2_cond        FI2 including any flag being set this cycle
//   rmt_*           partner header (8b) / data (12b) credits
// ---------------------------------------------------------------------------
module dll_fc_rx_tracker
    import dll_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  dlcm_state,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    input  logic        rx_tlp_valid,
    output logic        fi1_cond,
    output logic        fi2_cond,
    output logic [7:0]  rmt_ph,
    output logic [7:0]  rmt_nph,
    output logic [7:0]  rmt_cplh,
    output logic [11:0] rmt_pd,
    output logic [11:0] rmt_npd,
    output logic [11:0] rmt_cpld
);

    logic        rcvd_p, rcvd_np, rcvd_cpl, fi2;
    logic [7:0]  typ;
    logic [7:0]  hdr;
    logic [11:0] data;
    logic        in_init, hit_p, hit_np, hit_cpl, fi2_hit;

    // Full-byte compares reject nonzero VC IDs and every unknown type.
    assign typ     = dllp_type(rx_data);
    assign hdr     = dllp_hdr_fc(rx_data);
    assign data    = dllp_data_fc(rx_data);
    assign in_init = (dlcm_state == DLCM_INIT1) || (dlcm_state == DLCM_INIT2);

    assign hit_p   = rx_valid && in_init && (typ == DLLP_INITFC1_P   || typ == DLLP_INITFC2_P);
    assign hit_np  = rx_valid && in_init && (typ == DLLP_INITFC1_NP  || typ == DLLP_INITFC2_NP);
    assign hit_cpl = rx_valid && in_init && (typ == DLLP_INITFC1_CPL || typ == DLLP_INITFC2_CPL);

    assign fi2_hit = (dlcm_state == DLCM_INIT2) &&
                     (rx_tlp_valid ||
                      (rx_valid && (typ == DLLP_INITFC2_P || typ == DLLP_INITFC2_NP ||
                                    typ == DLLP_INITFC2_CPL || typ == DLLP_UPDFC_P ||
                                    typ == DLLP_UPDFC_NP || typ == DLLP_UPDFC_CPL)));

    // The TX FSM evaluates exit on the Cpl-accept cycle and must see flags
    // that are being set in that same cycle, hence the look-ahead terms.
    assign fi1_cond = (rcvd_p | hit_p) & (rcvd_np | hit_np) & (rcvd_cpl | hit_cpl);
    assign fi2_cond = fi2 | fi2_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcvd_p   <= 1'b0;
            rcvd_np  <= 1'b0;
            rcvd_cpl <= 1'b0;
            fi2      <= 1'b0;
            rmt_ph   <= '0;
            rmt_nph  <= '0;
            rmt_cplh <= '0;
            rmt_pd   <= '0;
            rmt_npd  <= '0;
            rmt_cpld <= '0;
        end else if (dlcm_state == DLCM_INACTIVE) begin
            rcvd_p   <= 1'b0;
            rcvd_np  <= 1'b0;
            rcvd_cpl <= 1'b0;
            fi2      <= 1'b0;
            rmt_ph   <= '0;
            rmt_nph  <= '0;
            rmt_cplh <= '0;
            rmt_pd   <= '0;
            rmt_npd  <= '0;
            rmt_cpld <= '0;
        end else begin
            // Only the first DLLP per type is latched.
            if (hit_p && !rcvd_p) begin
                rcvd_p <= 1'b1;
                rmt_ph <= hdr;
                rmt_pd <= data;
            end
            if (hit_np && !rcvd_np) begin
                rcvd_np <= 1'b1;
                rmt_nph <= hdr;
                rmt_npd <= data;
            end
            if (hit_cpl && !rcvd_cpl) begin
                rcvd_cpl <= 1'b1;
                rmt_cplh <= hdr;
                rmt_cpld <= data;
            end
            if (fi2_hit) begin
                fi2 <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dll_fc_init_gen.sv
// ---------------------------------------------------------------------------
// dll_fc_init_gen
// VC0 flow-control initialisation engine. Sends InitFC1/InitFC2 DLLP sets
// (P, NP, Cpl) to the DLLP transmit arbiter while the DLCM is in INIT1/INIT2,
// repeating each set after RESEND_CYCLES idle cycles until the phase exit
// condition (FI1 / FI2) holds, and reports init1_end_o / init2_end_o.
// Ports:
//   ssclk, srst_n          clock, asynchronous active-low reset
//   dlcm_state_i           0 INACTIVE, 1 INIT1, 2 INIT2, 3 ACTIVE
//   tx_dllp_valid_o/data_o DLLP request and body; held until tx_dllp_ready_i
//   rx_dllp_valid_i/data_i received DLLP
//   rx_tlp_valid_i         good TLP received
//   init1_end_o/init2_end_o sticky phase-complete levels
//   rmt_*_o                partner advertised credits
// ---------------------------------------------------------------------------
module dll_fc_init_gen
    import dll_pkg::*;
#(
    parameter logic [7:0]  LOC_PH        = 8'd32,
    parameter logic [11:0] LOC_PD        = 12'd256,
    parameter logic [7:0]  LOC_NPH       = 8'd32,
    parameter logic [11:0] LOC_NPD       = 12'd32,
    parameter logic [7:0]  LOC_CPLH      = 8'd0,
    parameter logic [11:0] LOC_CPLD      = 12'd0,
    parameter int          RESEND_CYCLES = 1024
)
(
    input  logic        ssclk,
    input  logic        srst_n,
    input  logic [1:0]  dlcm_state_i,
    output logic        tx_dllp_valid_o,
    output logic [31:0] tx_dllp_data_o,
    input  logic        tx_dllp_ready_i,
    input  logic        rx_dllp_valid_i,
    input  logic [31:0] rx_dllp_data_i,
    input  logic        rx_tlp_valid_i,
    output logic        init1_end_o,
    output logic        init2_end_o,
    output logic [7:0]  rmt_ph_o,
    output logic [7:0]  rmt_nph_o,
    output logic [7:0]  rmt_cplh_o,
    output logic [11:0] rmt_pd_o,
    output logic [11:0] rmt_npd_o,
    output logic [11:0] rmt_cpld_o
);

    localparam int TMR_W = $clog2(RESEND_CYCLES + 1);
    localparam logic [TMR_W-1:0] RESEND_LOAD = TMR_W'(RESEND_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_P,
        S_SEND_NP,
        S_SEND_CPL,
        S_WAIT
    } fsm_e;

    fsm_e             state;
    logic             phase2;   // 1: current set uses InitFC2 codes
    logic [TMR_W-1:0] timer;
    logic             fi1_cond, fi2_cond;
    logic             in_init1, in_init2;
    logic             start_ok, wait_exit, set_exit, accept;

    function automatic logic [31:0] fc_dllp(input logic init2, input fc_type_e t);
        logic [31:0] d;
        case (t)
            FC_P:    d = build_fc_dllp(init_fc_code(init2, FC_P),   LOC_PH,   LOC_PD);
            FC_NP:   d = build_fc_dllp(init_fc_code(init2, FC_NP),  LOC_NPH,  LOC_NPD);
            default: d = build_fc_dllp(init_fc_code(init2, FC_CPL), LOC_CPLH, LOC_CPLD);
        endcase
        return d;
    endfunction

    dll_fc_rx_tracker u_rx_tracker (
        .clk          (ssclk),
        .rst_n        (srst_n),
        .dlcm_state   (dlcm_state_i),
        .rx_valid     (rx_dllp_valid_i),
        .rx_data      (rx_dllp_data_i),
        .rx_tlp_valid (rx_tlp_valid_i),
        .fi1_cond     (fi1_cond),
        .fi2_cond     (fi2_cond),
        .rmt_ph       (rmt_ph_o),
        .rmt_nph      (rmt_nph_o),
        .rmt_cplh     (rmt_cplh_o),
        .rmt_pd       (rmt_pd_o),
        .rmt_npd      (rmt_npd_o),
        .rmt_cpld     (rmt_cpld_o)
    );

    assign in_init1 = (dlcm_state_i == DLCM_INIT1);
    assign in_init2 = (dlcm_state_i == DLCM_INIT2);
    assign accept   = tx_dllp_valid_o && tx_dllp_ready_i;

    // A finished phase must not restart sending while the DLCM is still
    // in that phase and has not yet moved on.
    assign start_ok  = (in_init1 && !init1_end_o) || (in_init2 && !init2_end_o);
    // Exit checked against the phase of the set just sent.
    assign set_exit  = phase2 ? fi2_cond : fi1_cond;
    // Early wake from S_WAIT uses the phase the next set will be sent in.
    assign wait_exit = (in_init1 && fi1_cond) || (in_init2 && fi2_cond);

    always_ff @(posedge ssclk or negedge srst_n) begin
        if (!srst_n) begin
            state           <= S_IDLE;
            phase2          <= 1'b0;
            timer           <= '0;
            tx_dllp_valid_o <= 1'b0;
            tx_dllp_data_o  <= '0;
            init1_end_o     <= 1'b0;
            init2_end_o     <= 1'b0;
        end else if (dlcm_state_i == DLCM_INACTIVE) begin
            state           <= S_IDLE;
            phase2          <= 1'b0;
            timer           <= '0;
            tx_dllp_valid_o <= 1'b0;
            tx_dllp_data_o  <= '0;
            init1_end_o     <= 1'b0;
            init2_end_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state           <= S_SEND_P;
                        phase2          <= in_init2;
                        tx_dllp_valid_o <= 1'b1;
                        tx_dllp_data_o  <= fc_dllp(in_init2, FC_P);
                    end
                end
                S_SEND_P: begin
                    if (accept) begin
                        state          <= S_SEND_NP;
                        tx_dllp_data_o <= fc_dllp(phase2, FC_NP);
                    end
                end
                S_SEND_NP: begin
                    if (accept) begin
                        state          <= S_SEND_CPL;
                        tx_dllp_data_o <= fc_dllp(phase2, FC_CPL);
                    end
                end
                S_SEND_CPL: begin
                    if (accept) begin
                        tx_dllp_valid_o <= 1'b0;
                        tx_dllp_data_o  <= '0;
                        if (set_exit) begin
                            if (phase2) begin
                                init2_end_o <= 1'b1;
                            end else begin
                                init1_end_o <= 1'b1;
                            end
                            state <= S_IDLE;
                        end else begin
                            timer <= RESEND_LOAD;
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!(in_init1 || in_init2)) begin
                        state <= S_IDLE;
                        timer <= '0;
                    end else if (wait_exit || timer <= TMR_W'(1)) begin
                        // Leaving as the count reaches 0 gives exactly
                        // RESEND_CYCLES cycles with valid low.
                        state           <= S_SEND_P;
                        phase2          <= in_init2;
                        timer           <= '0;
                        tx_dllp_valid_o <= 1'b1;
                        tx_dllp_data_o  <= fc_dllp(in_init2, FC_P);
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dll_fc_init_gen.sv
module tb_dll_fc_init_gen;

    logic        ssclk = 1'b0;
    logic        srst_n;
    logic [1:0]  dlcm;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_tlp;
    logic        init1_end, init2_end;
    logic [7:0]  rmt_ph, rmt_nph, rmt_cplh;
    logic [11:0] rmt_pd, rmt_npd, rmt_cpld;

    int total = 0;
    int bad   = 0;

    always #5 ssclk = ~ssclk;

    dll_fc_init_gen dut (
        .ssclk           (ssclk),
        .srst_n          (srst_n),
        .dlcm_state_i    (dlcm),
        .tx_dllp_valid_o (tx_valid),
        .tx_dllp_data_o  (tx_data),
        .tx_dllp_ready_i (tx_ready),
        .rx_dllp_valid_i (rx_valid),
        .rx_dllp_data_i  (rx_data),
        .rx_tlp_valid_i  (rx_tlp),
        .init1_end_o     (init1_end),
        .init2_end_o     (init2_end),
        .rmt_ph_o        (rmt_ph),
        .rmt_nph_o       (rmt_nph),
        .rmt_cplh_o      (rmt_cplh),
        .rmt_pd_o        (rmt_pd),
        .rmt_npd_o       (rmt_npd),
        .rmt_cpld_o      (rmt_cpld)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h want=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge ssclk);
    endtask

    task automatic rx_pulse(input logic [31:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
    endtask

    task automatic rx_idle();
        rx_valid = 1'b0;
        rx_data  = '0;
        rx_tlp   = 1'b0;
    endtask

    task automatic chk_all_clear(input string tag);
        chk({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
        chk({tag, "_data"}, tx_data, 32'd0);
        chk({tag, "_ends"}, {30'd0, init1_end, init2_end}, 32'd0);
        chk({tag, "_rmt_h"}, {8'd0, rmt_ph, rmt_nph, rmt_cplh}, 32'd0);
        chk({tag, "_rmt_d"}, {rmt_pd, rmt_npd, rmt_cpld[7:0]}, 32'd0);
        chk({tag, "_rmt_cpld"}, {20'd0, rmt_cpld}, 32'd0);
    endtask

    initial begin
        int low_cnt;
        srst_n   = 1'b0;
        dlcm     = 2'd0;
        tx_ready = 1'b0;
        rx_idle();
        repeat (3) step();
        chk_all_clear("reset");

        // ---- 1: INIT1 sets with no partner traffic
        srst_n   = 1'b1;
        dlcm     = 2'd1;
        tx_ready = 1'b1;
        step();
        chk("t1_p_valid", {31'd0, tx_valid}, 32'd1);
        chk("t1_p", tx_data, 32'h40080100);
        step();
        chk("t1_np", tx_data, 32'h50080020);
        step();
        chk("t1_cpl", tx_data, 32'h60000000);
        step();
        low_cnt = 0;
        while (!tx_valid && low_cnt < 2000) begin
            low_cnt++;
            step();
        end
        chk("t1_gap", low_cnt, 32'd1024);
        chk("t1_init1_end", {31'd0, init1_end}, 32'd0);

        // ---- 2: partner InitFC1 set arrives during set 2
        chk("t2_p", tx_data, 32'h40080100);
        rx_pulse(32'h40040080);
        step();
        chk("t2_np", tx_data, 32'h50080020);
        rx_pulse(32'h50080020);
        step();
        chk("t2_cpl", tx_data, 32'h60000000);
        chk("t2_end_early", {31'd0, init1_end}, 32'd0);
        rx_pulse(32'h60010005);
        step();
        rx_idle();
        chk("t2_init1_end", {31'd0, init1_end}, 32'd1);
        chk("t2_valid_off", {31'd0, tx_valid}, 32'd0);
        chk("t2_ph_pd", {12'd0, rmt_ph, rmt_pd}, {12'd0, 8'd16, 12'd128});
        chk("t2_nph_npd", {12'd0, rmt_nph, rmt_npd}, {12'd0, 8'd32, 12'd32});
        chk("t2_cplh_cpld", {12'd0, rmt_cplh, rmt_cpld}, {12'd0, 8'd4, 12'd5});
        rx_pulse(32'h400A0000);
        step();
        rx_idle();
        repeat (4) step();
        chk("t2_ph_hold", {24'd0, rmt_ph}, 32'd16);
        chk("t2_no_restart", {31'd0, tx_valid}, 32'd0);

        // ---- 3: exit condition arrives while waiting
        dlcm = 2'd0;
        step();
        chk("t3_inactive_end", {31'd0, init1_end}, 32'd0);
        chk("t3_inactive_ph", {24'd0, rmt_ph}, 32'd0);
        dlcm = 2'd1;
        repeat (4) step();
        chk("t3_wait_valid", {31'd0, tx_valid}, 32'd0);
        repeat (10) step();
        rx_pulse(32'h40080100);
        step();
        rx_pulse(32'h50080020);
        step();
        rx_pulse(32'h60000000);
        step();
        rx_idle();
        chk("t3_extra_p", tx_data, 32'h40080100);
        step();
        chk("t3_extra_np", tx_data, 32'h50080020);
        step();
        chk("t3_extra_cpl", tx_data, 32'h60000000);
        chk("t3_end_early", {31'd0, init1_end}, 32'd0);
        step();
        chk("t3_init1_end", {31'd0, init1_end}, 32'd1);
        repeat (3) step();
        chk("t3_one_set_only", {31'd0, tx_valid}, 32'd0);

        // ---- 4a: INIT2 ended by UpdateFC-P
        dlcm = 2'd2;
        step();
        chk("t4_p", tx_data, 32'hC0080100);
        rx_pulse(32'h80000000);
        step();
        rx_idle();
        chk("t4_np", tx_data, 32'hD0080020);
        step();
        chk("t4_cpl", tx_data, 32'hE0000000);
        chk("t4_end_early", {31'd0, init2_end}, 32'd0);
        step();
        chk("t4_init2_end", {31'd0, init2_end}, 32'd1);
        chk("t4_init1_sticky", {31'd0, init1_end}, 32'd1);
        dlcm = 2'd3;
        repeat (3) step();
        chk("t4_active_hold", {29'd0, tx_valid, init1_end, init2_end}, 32'd3);

        // ---- 4b: INIT2 ended by a TLP in the Cpl-accept cycle
        dlcm = 2'd0;
        step();
        dlcm = 2'd2;
        step();
        chk("t4b_p", tx_data, 32'hC0080100);
        step();
        step();
        chk("t4b_cpl", tx_data, 32'hE0000000);
        rx_tlp = 1'b1;
        step();
        rx_idle();
        chk("t4b_init2_end", {30'd0, tx_valid, init2_end}, 32'd1);

        // ---- 5: back-pressure during NP
        dlcm = 2'd0;
        step();
        dlcm = 2'd1;
        step();
        chk("t5_p", tx_data, 32'h40080100);
        step();
        chk("t5_np", tx_data, 32'h50080020);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_np_hold", {tx_valid, tx_data[30:0]}, {1'b1, 31'h50080020});
        end
        tx_ready = 1'b1;
        step();
        chk("t5_cpl", tx_data, 32'h60000000);
        step();
        chk("t5_done", {31'd0, tx_valid}, 32'd0);

        // ---- 6a: INACTIVE mid-set
        dlcm = 2'd0;
        step();
        dlcm = 2'd1;
        step();
        rx_pulse(32'h40040080);
        step();
        rx_idle();
        chk("t6_np", tx_data, 32'h50080020);
        chk("t6_ph", {24'd0, rmt_ph}, 32'd16);
        dlcm = 2'd0;
        step();
        chk_all_clear("t6_inactive");
        step();
        chk("t6_stay_idle", {31'd0, tx_valid}, 32'd0);

        // ---- 6b: asynchronous reset mid-set
        dlcm = 2'd1;
        step();
        rx_pulse(32'h40040080);
        step();
        rx_idle();
        chk("t6b_np", tx_data, 32'h50080020);
        #2;
        srst_n = 1'b0;
        #1;
        chk_all_clear("t6b_areset");
        step();
        srst_n = 1'b1;
        step();
        chk("t6b_restart", tx_data, 32'h40080100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dll_fc_init_gen.md
Name: dll_fc_init_gen

Overview:
- Data-link-layer flow-control initialisation engine for VC0.
- Transmits the InitFC1 and InitFC2 DLLP sets while the DLCM state machine is in INIT1/INIT2.
- Records InitFC/UpdateFC DLLPs received from the link partner and latches the partner's advertised credits.
- Produces the init1_end/init2_end qualifiers consumed by the DLCM state machine; sits directly upstream of it and alongside the DLLP transmit arbiter.

Parameters:
- LOC_PH, 8'd32: local posted header credits advertised.
- LOC_PD, 12'd256: local posted data credits.
- LOC_NPH, 8'd32: local non-posted header credits.
- LOC_NPD, 12'd32: local non-posted data credits.
- LOC_CPLH, 8'd0: local completion header credits (0 = infinite).
- LOC_CPLD, 12'd0: local completion data credits (0 = infinite).
- RESEND_CYCLES, 1024: idle cycles between repeated DLLP sets; counter width is $clog2(RESEND_CYCLES+1).

Ports:
- ssclk  in  1  clock.
- srst_n  in  1  asynchronous active-low reset.
- dlcm_state_i  in  2  DLCM state: 0 INACTIVE, 1 INIT1, 2 INIT2, 3 ACTIVE.
- tx_dllp_valid_o  out  1  DLLP request to the transmit arbiter.
- tx_dllp_data_o  out  32  DLLP body without CRC; byte0 in [31:24].
- tx_dllp_ready_i  in  1  arbiter accepts this cycle.
- rx_dllp_valid_i  in  1  CRC-checked received DLLP.
- rx_dllp_data_i  in  32  received DLLP body, same layout as transmit.
- rx_tlp_valid_i  in  1  good TLP received; sets FI2.
- init1_end_o  out  1  FC_INIT1 complete, to the DLCM state machine.
- init2_end_o  out  1  FC_INIT2 complete, to the DLCM state machine.
- rmt_ph_o, rmt_nph_o, rmt_cplh_o  out  8 each  partner header credits.
- rmt_pd_o, rmt_npd_o, rmt_cpld_o  out  12 each  partner data credits.

Behaviour:
- Reset values: all outputs 0, FSM in S_IDLE, FI1/FI2 and per-type received flags cleared, timer 0.
- DLLP encoding:
  - byte0 type: InitFC1 P/NP/Cpl = 0x40/0x50/0x60; InitFC2 = 0xC0/0xD0/0xE0; UpdateFC = 0x80/0x90/0xA0. Bits [2:0] carry VC ID and must be 0.
  - byte1 = {2'b00, HdrFC[7:2]}.
  - byte2 = {HdrFC[1:0], 2'b00, DataFC[11:8]}.
  - byte3 = DataFC[7:0].
- Received DLLPs with a nonzero VC field or any other type are ignored.
- FSM states: S_IDLE, S_SEND_P, S_SEND_NP, S_SEND_CPL, S_WAIT.
  - S_IDLE → S_SEND_P when dlcm_state_i is INIT1 or INIT2.
  - Sending phase is INIT1 → InitFC1 type codes; INIT2 → InitFC2 type codes. The type is resampled at S_SEND_P entry.
  - In S_SEND_x, tx_dllp_valid_o = 1 and data is held stable until tx_dllp_ready_i. The handshake completes the same cycle valid and ready are both high; move to the next state on the following cycle.
  - Back-to-back sends are allowed, so a full set takes a minimum of 3 cycles.
  - After the Cpl handshake: if the phase exit condition holds, set the phase end flag and go to S_IDLE. Otherwise load the timer with RESEND_CYCLES and go to S_WAIT.
  - S_WAIT: decrement the timer each cycle; at 0, go to S_SEND_P. If the exit condition becomes true while in S_WAIT, go immediately to S_SEND_P to send one more full set before ending.
- Received-set tracking: in INIT1 or INIT2, a received InitFC1 or InitFC2 of type X sets rcvd_X. On the first such DLLP per type, latch HdrFC/DataFC into the matching rmt_* outputs. Later DLLPs never overwrite the rmt_* outputs.
- FI1 = rcvd_P & rcvd_NP & rcvd_CPL.
- FI2 is set in INIT2 by any received InitFC2, any UpdateFC, or rx_tlp_valid_i.
- Exit conditions:
  - INIT1 exits on FI1.
  - INIT2 exits on FI2.
  - The condition is evaluated on the Cpl-accept cycle and includes a flag being set in that same cycle.
- init1_end_o and init2_end_o are sticky levels. They set 1 cycle after the qualifying Cpl handshake and clear only when dlcm_state_i is INACTIVE.
- In ACTIVE: the FSM stays in S_IDLE; flags and rmt_* values hold.
- dlcm_state_i = INACTIVE in any state:
  - Next cycle: FSM returns to S_IDLE, valid drops (this is the only case where valid may drop unaccepted).
  - All flags, end outputs, rmt_* outputs and the timer clear.
- INIT1→INIT2 transition mid-set: the current set completes with InitFC1 codes; the next set uses InitFC2 codes.
- rx and tx events in the same cycle are independent; neither is lost.

Decomposition:
- Shared package dll_pkg:
  - DLCM state enum (INACTIVE/INIT1/INIT2/ACTIVE).
  - DLLP type constants.
  - FC type enum (P/NP/CPL).
  - Function build_fc_dllp(type, hdr, data) and field-extract helpers.
- One sub-module dll_fc_rx_tracker: receive decode, rcvd/FI1/FI2 flags, rmt_* latches. The parent holds the TX FSM and timer.

Test Plan:
1. Reset, dlcm=INIT1, ready=1, no rx → sets with data 0x40080100 (P, LOC_PH=32, LOC_PD=256), 0x50080020, 0x60000000; 1024 idle cycles between sets; init1_end_o stays 0.
2. In INIT1, rx InitFC1 P/NP/Cpl with P=0x40040080 during set 2 → rmt_ph_o=16, rmt_pd_o=128; set 2 completes; init1_end_o=1 one cycle after its Cpl accept.
3. Exit condition becomes true while in S_WAIT → exactly one additional full set is sent, then init1_end_o asserts.
4. dlcm=INIT2 → sets 0xC0…/0xD0…/0xE0… sent; rx UpdateFC-P (0x80…) → init2_end_o after the current set completes; a second test substitutes rx_tlp_valid_i pulse → same result.
5. Ready held low 5 cycles during NP → data stable at 0x50080020, valid high throughout, no skip.
6. dlcm=INACTIVE mid-set; separately, srst_n pulsed asynchronously mid-set → outputs, flags and rmt_* all 0, FSM in S_IDLE.
